// File: rtl/key_cmd_decoder_pkg.sv
// Shared definitions for the keyboard command decoder.
// Holds the command bit indices, the USB HID usage codes that map onto
// commands, the repeat-FSM state encoding and the key-slot search helper.
package key_cmd_decoder_pkg;

    // Command vector layout (cmd / held bit positions)
    localparam int NUM_CMDS  = 5;
    localparam int CMD_LEFT  = 0;
    localparam int CMD_RIGHT = 1;
    localparam int CMD_DOWN  = 2;
    localparam int CMD_ROT_L = 3;
    localparam int CMD_ROT_R = 4;

    // Left, right and down are the commands that may auto-repeat; they
    // occupy the low bits of the command vector.
    localparam int NUM_RPT = 3;

    // Width of each repeat FSM's frame-tick counter
    localparam int CNT_W = 6;

    // Number of 8-bit usage-code slots in the keycode word
    localparam int NUM_SLOTS = 4;

    // USB HID usage codes
    localparam logic [7:0] HID_EMPTY = 8'h00;
    localparam logic [7:0] HID_LEFT  = 8'h50;  // Left arrow
    localparam logic [7:0] HID_RIGHT = 8'h4F;  // Right arrow
    localparam logic [7:0] HID_DOWN  = 8'h51;  // Down arrow
    localparam logic [7:0] HID_Z     = 8'h1D;  // rotate left
    localparam logic [7:0] HID_UP    = 8'h52;  // rotate right
    localparam logic [7:0] HID_X     = 8'h1B;  // rotate right (alternate)

    // Repeat FSM states
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // True when the given usage code sits in any of the keycode slots.
    // An empty-slot code is never reported as a key.
    function automatic logic key_present(input logic [31:0] keys,
                                         input logic [7:0]  code);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (keys[s*8 +: 8] == code && code != HID_EMPTY) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_cmd_decoder_repeat_fsm.sv
// key_repeat_fsm: press/auto-repeat pulse generator for one command.
// A rising press produces a pulse immediately; after `delay` frame ticks a
// second pulse is produced, and then one every `period` ticks while the key
// stays down. Releasing the key returns to IDLE without a pulse. The tick
// counter clears whenever a state is (re)entered and advances only on tick.
module key_repeat_fsm
    import key_cmd_decoder_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             press,
    input  logic             tick,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] period,
    output logic             pulse
);

    rpt_state_t       state_reg;
    rpt_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             restart;
    logic             delay_hit;
    logic             period_hit;

    // A hit is the tick that completes the programmed number of ticks
    assign delay_hit  = tick && (count_reg == delay - CNT_W'(1));
    assign period_hit = tick && (count_reg == period - CNT_W'(1));

    // State and tick counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= RPT_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state; restart flags a state entry so the counter starts over
    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        case (state_reg)
            RPT_IDLE: begin
                if (press) begin
                    state_next = RPT_DELAY;
                    restart    = 1'b1;
                end
            end
            RPT_DELAY: begin
                if (!press) begin
                    state_next = RPT_IDLE;
                    restart    = 1'b1;
                end else if (delay_hit) begin
                    state_next = RPT_REPEAT;
                    restart    = 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (!press) begin
                    state_next = RPT_IDLE;
                    restart    = 1'b1;
                end else if (period_hit) begin
                    restart    = 1'b1;
                end
            end
            default: begin
                state_next = RPT_IDLE;
                restart    = 1'b1;
            end
        endcase

        if (restart || state_reg == RPT_IDLE) begin
            count_next = '0;
        end else if (tick) begin
            count_next = count_reg + CNT_W'(1);
        end else begin
            count_next = count_reg;
        end
    end

    // Pulse output: on the press itself and on each completed delay/period
    always_comb begin
        pulse = 1'b0;
        case (state_reg)
            RPT_IDLE:   pulse = press;
            RPT_DELAY:  pulse = press && delay_hit;
            RPT_REPEAT: pulse = press && period_hit;
            default:    pulse = 1'b0;
        endcase
    end

endmodule

// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: turns the four-slot HID keycode word written by software
// into one-cycle game commands (left, right, down, rotate left/right) and a
// registered per-command "held" level.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   -> left/right/down auto-repeat through key_repeat_fsm using
//                DAS_DELAY / ARR_PERIOD / DROP_PERIOD frame ticks
//   undefined -> every command is edge-only (one pulse per press) and the
//                timing parameters have no effect
//
// Latency: keycode -> key_q_reg (1 cycle) -> held_reg / cmd_reg (1 cycle).
// While BOARD_BUSY is high, due pulses are parked in pending_reg and issued
// in the first cycle the board is free again.
module key_cmd_decoder
    import key_cmd_decoder_pkg::*;
#(
    parameter int DAS_DELAY   = 10,
    parameter int ARR_PERIOD  = 3,
    parameter int DROP_PERIOD = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [31:0]         keycode,
    input  logic                frame_clk_rising_edge,
    input  logic                BOARD_BUSY,
    output logic [NUM_CMDS-1:0] cmd,
    output logic [NUM_CMDS-1:0] held
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Timing parameters must fit the 6-bit tick counters and be non-zero
    if (DAS_DELAY < 1 || DAS_DELAY > CNT_MAX ||
        ARR_PERIOD < 1 || ARR_PERIOD > CNT_MAX ||
        DROP_PERIOD < 1 || DROP_PERIOD > CNT_MAX) begin : g_bad_timing
        $error("key_cmd_decoder: DAS_DELAY, ARR_PERIOD and DROP_PERIOD must lie in 1..63");
    end

    logic [31:0]         key_q_reg;
    logic [NUM_CMDS-1:0] pressed;
    logic [NUM_CMDS-1:0] held_reg;
    logic [NUM_CMDS-1:0] cmd_reg;
    logic [NUM_CMDS-1:0] cmd_next;
    logic [NUM_CMDS-1:0] pending_reg;
    logic [NUM_CMDS-1:0] pending_next;
    logic [NUM_CMDS-1:0] due;
    logic [NUM_RPT-1:0]  rpt_press;
    logic [NUM_RPT-1:0]  rpt_due;
    logic                rot_r_rise;
    logic                rot_l_rise;

    genvar gi;

    // Decode which commands are currently pressed from the registered keys
    always_comb begin
        pressed            = '0;
        pressed[CMD_LEFT]  = key_present(key_q_reg, HID_LEFT);
        pressed[CMD_RIGHT] = key_present(key_q_reg, HID_RIGHT);
        pressed[CMD_DOWN]  = key_present(key_q_reg, HID_DOWN);
        pressed[CMD_ROT_L] = key_present(key_q_reg, HID_Z);
        pressed[CMD_ROT_R] = key_present(key_q_reg, HID_UP) |
                             key_present(key_q_reg, HID_X);
    end

    // Left and right cancel each other: while both are down neither is
    // considered pressed, so the survivor looks like a fresh press later.
    assign rpt_press[CMD_LEFT]  = pressed[CMD_LEFT]  & ~pressed[CMD_RIGHT];
    assign rpt_press[CMD_RIGHT] = pressed[CMD_RIGHT] & ~pressed[CMD_LEFT];
    assign rpt_press[CMD_DOWN]  = pressed[CMD_DOWN];

`ifdef KEY_AUTOREPEAT_EN
    // One repeat engine per movement command; down uses its own cadence
    for (gi = 0; gi < NUM_RPT; gi++) begin : g_rpt
        localparam logic [CNT_W-1:0] DLY =
            (gi == CMD_DOWN) ? CNT_W'(DROP_PERIOD) : CNT_W'(DAS_DELAY);
        localparam logic [CNT_W-1:0] PER =
            (gi == CMD_DOWN) ? CNT_W'(DROP_PERIOD) : CNT_W'(ARR_PERIOD);

        key_repeat_fsm u_fsm (
            .Clk    (Clk),
            .Reset  (Reset),
            .press  (rpt_press[gi]),
            .tick   (frame_clk_rising_edge),
            .delay  (DLY),
            .period (PER),
            .pulse  (rpt_due[gi])
        );
    end
`else
    logic [NUM_RPT-1:0] rpt_press_prev;
    logic               tick_unused;

    // Without auto-repeat the frame tick is not needed
    assign tick_unused = frame_clk_rising_edge;

    // Previous-cycle effective press, rebuilt from the held levels
    assign rpt_press_prev[CMD_LEFT]  = held_reg[CMD_LEFT]  & ~held_reg[CMD_RIGHT];
    assign rpt_press_prev[CMD_RIGHT] = held_reg[CMD_RIGHT] & ~held_reg[CMD_LEFT];
    assign rpt_press_prev[CMD_DOWN]  = held_reg[CMD_DOWN];

    // Edge-only movement: pulse once when the effective press rises
    for (gi = 0; gi < NUM_RPT; gi++) begin : g_edge
        assign rpt_due[gi] = rpt_press[gi] & ~rpt_press_prev[gi];
    end
`endif

    // Rotations never repeat; a simultaneous rise favours rotate right
    assign rot_r_rise = pressed[CMD_ROT_R] & ~held_reg[CMD_ROT_R];
    assign rot_l_rise = pressed[CMD_ROT_L] & ~held_reg[CMD_ROT_L] & ~rot_r_rise;

    // Gather every pulse that is due this cycle
    always_comb begin
        due            = '0;
        due[CMD_LEFT]  = rpt_due[CMD_LEFT];
        due[CMD_RIGHT] = rpt_due[CMD_RIGHT];
        due[CMD_DOWN]  = rpt_due[CMD_DOWN];
        due[CMD_ROT_L] = rot_l_rise;
        due[CMD_ROT_R] = rot_r_rise;
    end

    // Busy gating: park due pulses while busy, release them (merged with any
    // fresh pulse of the same command) in the first free cycle
    for (gi = 0; gi < NUM_CMDS; gi++) begin : g_issue
        assign cmd_next[gi]     = ~BOARD_BUSY & (pending_reg[gi] | due[gi]);
        assign pending_next[gi] =  BOARD_BUSY & (pending_reg[gi] | due[gi]);
    end

    // Key sampling, held levels, command pulses and pending bits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q_reg   <= '0;
            held_reg    <= '0;
            cmd_reg     <= '0;
            pending_reg <= '0;
        end else begin
            key_q_reg   <= keycode;
            held_reg    <= pressed;
            cmd_reg     <= cmd_next;
            pending_reg <= pending_next;
        end
    end

    assign cmd  = cmd_reg;
    assign held = held_reg;

endmodule
